// File: rtl/noc_pkg.sv
// Shared NoC width helpers so routers, buffers and credit counters agree on
// VC-id and credit-count widths.
package noc_pkg;

  localparam int FLIT_W = 32;

  typedef logic [FLIT_W-1:0] flit_t;

  function automatic int vc_id_w(input int num_vc);
    return (num_vc > 1) ? $clog2(num_vc) : 1;
  endfunction

  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/vc_fifo_lane.sv
// One virtual-channel lane: circular flit store with free-slot credit count.
// VC_INPUT_BUFFER_ERR_EN adds sticky overflow/underflow flags.
module vc_fifo_lane
  import noc_pkg::*;
#(
  parameter  int DEPTH        = 4,
  parameter  int DATA_WIDTH   = 32,
  parameter  int AFULL_THRESH = 1,
  localparam int CNT_W        = credit_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  afull,
`ifdef VC_INPUT_BUFFER_ERR_EN
  output logic                  err_ovf,
  output logic                  err_udf,
`endif
  output logic [CNT_W-1:0]      n_free
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      n_free_q, n_free_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  full, wr_en, rd_en;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full     = (n_free_q == '0);
    empty    = (n_free_q == CNT_W'(DEPTH));
    afull    = (int'(n_free_q) <= AFULL_THRESH);
    rd_en    = pop && !empty;
    wr_en    = push && (!full || pop);
    wr_ptr_d = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_en ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    n_free_d = n_free_q;
    case ({wr_en, rd_en})
      2'b10:   n_free_d = n_free_q - 1'b1;
      2'b01:   n_free_d = n_free_q + 1'b1;
      default: n_free_d = n_free_q;
    endcase
    dout   = empty ? '0 : mem_q[rd_ptr_q];
    n_free = n_free_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      n_free_q <= CNT_W'(DEPTH);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      n_free_q <= n_free_d;
    end
  end

  // Storage carries no reset; an empty lane masks it at dout.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= din;
  end

`ifdef VC_INPUT_BUFFER_ERR_EN
  logic err_ovf_q, err_ovf_d, err_udf_q, err_udf_d;

  always_comb begin
    err_ovf_d = err_ovf_q | (push && full && !pop);
    err_udf_d = err_udf_q | (pop && empty);
    err_ovf   = err_ovf_q;
    err_udf   = err_udf_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end
`endif

endmodule

// File: rtl/vc_input_buffer.sv
// Router input buffer: NUM_VC independent lanes behind one write port.
// VC_INPUT_BUFFER_ERR_EN adds sticky err_ovf/err_udf outputs.
module vc_input_buffer
  import noc_pkg::*;
#(
  parameter  int NUM_VC       = 2,
  parameter  int DEPTH        = 4,
  parameter  int DATA_WIDTH   = 32,
  parameter  int AFULL_THRESH = 1,
  localparam int VC_W         = vc_id_w(NUM_VC),
  localparam int CNT_W        = credit_w(DEPTH)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         push,
  input  logic [VC_W-1:0]              push_vc,
  input  logic [DATA_WIDTH-1:0]        din,
  input  logic [NUM_VC-1:0]            pop,
  output logic [NUM_VC*DATA_WIDTH-1:0] dout,
  output logic [NUM_VC-1:0]            empty,
  output logic [NUM_VC-1:0]            afull,
`ifdef VC_INPUT_BUFFER_ERR_EN
  output logic [NUM_VC-1:0]            err_ovf,
  output logic [NUM_VC-1:0]            err_udf,
`endif
  output logic [NUM_VC*CNT_W-1:0]      n_free
);

  logic [NUM_VC-1:0] lane_push;

  // An out-of-range push_vc matches no lane, so the flit is dropped.
  always_comb begin
    lane_push = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      lane_push[v] = push && (int'(push_vc) == v);
    end
  end

`ifdef VC_INPUT_BUFFER_ERR_EN
  logic [NUM_VC-1:0] lane_ovf;
  logic              bad_vc_q, bad_vc_d;

  always_comb begin
    bad_vc_d = bad_vc_q | (push && (int'(push_vc) >= NUM_VC));
    err_ovf  = lane_ovf | NUM_VC'(bad_vc_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bad_vc_q <= 1'b0;
    else          bad_vc_q <= bad_vc_d;
  end
`endif

  for (genvar g = 0; g < NUM_VC; g++) begin : g_lane
    vc_fifo_lane #(
      .DEPTH        (DEPTH),
      .DATA_WIDTH   (DATA_WIDTH),
      .AFULL_THRESH (AFULL_THRESH)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (lane_push[g]),
      .pop     (pop[g]),
      .din     (din),
      .dout    (dout[g*DATA_WIDTH +: DATA_WIDTH]),
      .empty   (empty[g]),
      .afull   (afull[g]),
`ifdef VC_INPUT_BUFFER_ERR_EN
      .err_ovf (lane_ovf[g]),
      .err_udf (err_udf[g]),
`endif
      .n_free  (n_free[g*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_vc_input_buffer.sv
// Randomized + directed bench for vc_input_buffer against a queue-based model;
// instance A is 2 lanes x 4 deep, instance B is 3 lanes x 3 deep.
module tb_vc_input_buffer;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  logic        push_a;
  logic [0:0]  pvc_a;
  logic [31:0] din_a;
  logic [1:0]  pop_a;
  logic [63:0] dout_a;
  logic [1:0]  empty_a, afull_a;
  logic [5:0]  nfree_a;

  logic        push_b;
  logic [1:0]  pvc_b;
  logic [31:0] din_b;
  logic [2:0]  pop_b;
  logic [95:0] dout_b;
  logic [2:0]  empty_b, afull_b;
  logic [8:0]  nfree_b;

`ifdef VC_INPUT_BUFFER_ERR_EN
  logic [1:0] eovf_a, eudf_a;
  logic [2:0] eovf_b, eudf_b;
`endif

  vc_input_buffer #(.NUM_VC(2), .DEPTH(4), .DATA_WIDTH(32), .AFULL_THRESH(1)) dut (
    .clk(clk), .reset_n(reset_n), .push(push_a), .push_vc(pvc_a), .din(din_a),
    .pop(pop_a), .dout(dout_a), .empty(empty_a), .afull(afull_a),
`ifdef VC_INPUT_BUFFER_ERR_EN
    .err_ovf(eovf_a), .err_udf(eudf_a),
`endif
    .n_free(nfree_a));

  vc_input_buffer #(.NUM_VC(3), .DEPTH(3), .DATA_WIDTH(32), .AFULL_THRESH(1)) dut3 (
    .clk(clk), .reset_n(reset_n), .push(push_b), .push_vc(pvc_b), .din(din_b),
    .pop(pop_b), .dout(dout_b), .empty(empty_b), .afull(afull_b),
`ifdef VC_INPUT_BUFFER_ERR_EN
    .err_ovf(eovf_b), .err_udf(eudf_b),
`endif
    .n_free(nfree_b));

  logic [31:0] mq [2][3][$];
  bit          movf [2][3];
  bit          mudf [2][3];
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_clear();
    for (int i = 0; i < 2; i++)
      for (int v = 0; v < 3; v++) begin
        mq[i][v].delete();
        movf[i][v] = 1'b0;
        mudf[i][v] = 1'b0;
      end
  endtask

  // Queue model: occupancy is the queue size, the head is the front element.
  task automatic mdl_step(input int inst, input int nvc, input int depth, input bit psh,
                          input int pvc, input logic [31:0] d, input logic [2:0] pp);
    if (psh && pvc >= nvc) movf[inst][0] = 1'b1;
    for (int v = 0; v < nvc; v++) begin
      int  sz;
      bit  wr;
      sz = mq[inst][v].size();
      wr = psh && (pvc == v);
      if (wr && sz == depth && !pp[v]) movf[inst][v] = 1'b1;
      if (pp[v] && sz == 0) mudf[inst][v] = 1'b1;
      if (pp[v] && sz > 0) void'(mq[inst][v].pop_front());
      if (wr && (sz < depth || pp[v])) mq[inst][v].push_back(d);
    end
  endtask

  task automatic check_all(input int inst, input string tag);
    int nvc, depth;
    nvc   = (inst == 0) ? 2 : 3;
    depth = (inst == 0) ? 4 : 3;
    for (int v = 0; v < nvc; v++) begin
      int          sz, nf;
      logic [31:0] ed, od;
      logic        oe, oa;
      logic [2:0]  on;
      sz = mq[inst][v].size();
      nf = depth - sz;
      ed = (sz > 0) ? mq[inst][v][0] : 32'h0;
      if (inst == 0) begin
        od = dout_a[v*32 +: 32]; oe = empty_a[v]; oa = afull_a[v]; on = nfree_a[v*3 +: 3];
      end else begin
        od = dout_b[v*32 +: 32]; oe = empty_b[v]; oa = afull_b[v]; on = nfree_b[v*3 +: 3];
      end
      chk_eq($sformatf("%s i%0d l%0d dout", tag, inst, v), 64'(od), 64'(ed));
      chk_eq($sformatf("%s i%0d l%0d empty", tag, inst, v), 64'(oe), 64'(sz == 0));
      chk_eq($sformatf("%s i%0d l%0d afull", tag, inst, v), 64'(oa), 64'(nf <= 1));
      chk_eq($sformatf("%s i%0d l%0d n_free", tag, inst, v), 64'(on), 64'(nf));
`ifdef VC_INPUT_BUFFER_ERR_EN
      if (inst == 0) begin
        chk_eq($sformatf("%s i0 l%0d err_ovf", tag, v), 64'(eovf_a[v]), 64'(movf[0][v]));
        chk_eq($sformatf("%s i0 l%0d err_udf", tag, v), 64'(eudf_a[v]), 64'(mudf[0][v]));
      end else begin
        chk_eq($sformatf("%s i1 l%0d err_ovf", tag, v), 64'(eovf_b[v]), 64'(movf[1][v]));
        chk_eq($sformatf("%s i1 l%0d err_udf", tag, v), 64'(eudf_b[v]), 64'(mudf[1][v]));
      end
`endif
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    if (reset_n) begin
      mdl_step(0, 2, 4, push_a, int'(pvc_a), din_a, {1'b0, pop_a});
      mdl_step(1, 3, 3, push_b, int'(pvc_b), din_b, pop_b);
    end
    #1;
    check_all(0, tag);
    check_all(1, tag);
  endtask

  task automatic drive_a(input string tag, input bit p, input int vc,
                         input logic [31:0] d, input logic [1:0] pp);
    push_a = p;
    pvc_a  = 1'(vc);
    din_a  = d;
    pop_a  = pp;
    step(tag);
  endtask

  initial begin
    push_a = 0; pvc_a = 0; din_a = 0; pop_a = 0;
    push_b = 0; pvc_b = 0; din_b = 0; pop_b = 0;
    mdl_clear();

    // Reset: asynchronous assertion, checked before any clock edge
    #2 reset_n = 1'b0;
    #1 check_all(0, "reset");
    check_all(1, "reset");
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 2; i++) drive_a("idle", 0, 0, 0, 2'b00);

    // Fill lane 1, overflow attempt, then drain plus one underflow pop
    for (int i = 0; i < 5; i++) drive_a("fill1", 1, 1, 32'hA0 + 32'(i), 2'b00);
    for (int i = 0; i < 5; i++) drive_a("drain1", 0, 0, 0, 2'b10);

    // Full lane 0 with simultaneous push and pop
    for (int i = 0; i < 4; i++) drive_a("fill0", 1, 0, 32'h10 + 32'(i), 2'b00);
    drive_a("fullpp", 1, 0, 32'h14, 2'b01);
    for (int i = 0; i < 4; i++) drive_a("drain0", 0, 0, 0, 2'b01);

    // Empty lane push + pop same cycle: write only
    drive_a("emptypp", 1, 1, 32'h55, 2'b10);
    drive_a("emptypp2", 0, 0, 0, 2'b00);
    drive_a("emptypp3", 0, 0, 0, 2'b10);

    // Randomized traffic on both instances, including illegal push_vc on B
    for (int i = 0; i < 400; i++) begin
      push_a = 1'($urandom_range(0, 1));
      pvc_a  = 1'($urandom_range(0, 1));
      din_a  = $urandom;
      pop_a  = 2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3));
      push_b = 1'($urandom_range(0, 1));
      pvc_b  = 2'($urandom_range(0, 3));
      din_b  = $urandom;
      pop_b  = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      step("rand");
    end
    push_b = 0; pop_b = 0;

    // Reset asserted mid-pop with flits queued
    drive_a("pre", 0, 0, 0, 2'b11);
    drive_a("pre", 0, 0, 0, 2'b11);
    drive_a("q0", 1, 0, 32'hC0, 2'b00);
    drive_a("q1", 1, 0, 32'hC1, 2'b00);
    push_a = 0;
    pop_a  = 2'b01;
    #2 reset_n = 1'b0;
    mdl_clear();
    #1 check_all(0, "midreset");
    check_all(1, "midreset");
    pop_a = 2'b00;
    @(posedge clk);
    #1 reset_n = 1'b1;
    drive_a("post", 0, 0, 0, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
